// File: rtl/spi_reg_frame_ctrl.sv
// Frame controller above the SPI byte slave: command byte + auto-incrementing burst onto a register bus.
// Optional frame-abort timeout enabled with `define SPI_TIMEOUT_EN.
module spi_reg_frame_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] IDLE_TX     = 8'hA5,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic              sysClk,
  input  logic              rstN,
  input  logic              ssN,
  input  logic [7:0]        rxByte,
  input  logic              rxValid,
  output logic [7:0]        txByte,
  output logic [ADDR_W-1:0] regAddr,
  output logic              regWrEn,
  output logic [7:0]        regWrData,
  output logic              regRdEn,
  input  logic [7:0]        regRdData,
  output logic              frameActive,
  output logic [7:0]        errCount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;
  localparam logic [7:0] ABORT_TX = 8'hEE;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              ss_meta, ss_s, ss_d;
  logic              frame_start, frame_end;
  logic              busy;
  logic              abort_go;

  // Sync flops idle high so a reset with SS already low still yields a frame start.
  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) begin
      ss_meta <= 1'b1;
      ss_s    <= 1'b1;
      ss_d    <= 1'b1;
    end else begin
      ss_meta <= ssN;
      ss_s    <= ss_meta;
      ss_d    <= ss_s;
    end
  end

  assign frame_start = ss_d & ~ss_s;
  assign frame_end   = ~ss_d & ss_s;
  assign busy        = (state == S_CMD) || (state == S_WDATA) || (state == S_RDATA);

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN)                      tmo_cnt <= '0;
    else if (frame_start || rxValid) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LIM)    tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A byte arriving on the expiry cycle or a concurrent frame end wins over the abort.
  assign abort_go = busy && (tmo_cnt == TMO_LIM) && !rxValid && !frame_end;

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN)                              errCount <= '0;
    else if (abort_go && errCount != 8'hFF) errCount <= errCount + 8'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
  assign abort_go   = 1'b0;
  assign errCount   = '0;
`endif

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) begin
      state       <= S_IDLE;
      addr        <= '0;
      txByte      <= IDLE_TX;
      regAddr     <= '0;
      regWrEn     <= 1'b0;
      regWrData   <= '0;
      regRdEn     <= 1'b0;
      frameActive <= 1'b0;
    end else begin
      regWrEn <= 1'b0;
      regRdEn <= 1'b0;
      case (state)
        S_IDLE: if (frame_start) begin
          state       <= S_CMD;
          frameActive <= 1'b1;
          txByte      <= IDLE_TX;
        end
        S_CMD: if (rxValid) begin
          addr <= rxByte[ADDR_W-1:0];
          if (rxByte[7]) begin
            state   <= S_RDATA;
            regAddr <= rxByte[ADDR_W-1:0];
            regRdEn <= 1'b1;
          end else begin
            state <= S_WDATA;
          end
        end
        S_WDATA: if (rxValid) begin
          regWrEn   <= 1'b1;
          regWrData <= rxByte;
          regAddr   <= addr;
          addr      <= addr + ADDR_ONE;
          txByte    <= rxByte;
        end
        S_RDATA: begin
          // Read data returns the cycle after the strobe; master's dummy bytes are ignored.
          if (regRdEn) txByte <= regRdData;
          if (rxValid) begin
            addr    <= addr + ADDR_ONE;
            regAddr <= addr + ADDR_ONE;
            regRdEn <= 1'b1;
          end
        end
        S_ABORT: txByte <= ABORT_TX;
        default: state <= S_IDLE;
      endcase
      if (abort_go) begin
        state  <= S_ABORT;
        txByte <= ABORT_TX;
      end
      if (frame_end) begin
        state       <= S_IDLE;
        txByte      <= IDLE_TX;
        frameActive <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_frame_ctrl.sv
// Directed bench for spi_reg_frame_ctrl; the register file is modelled here and written only through the DUT.
module tb_spi_reg_frame_ctrl;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ssN;
  logic [7:0] rxByte;
  logic       rxValid;
  logic [7:0] txByte;
  logic [6:0] regAddr;
  logic       regWrEn;
  logic [7:0] regWrData;
  logic       regRdEn;
  logic [7:0] regRdData;
  logic       frameActive;
  logic [7:0] errCount;

  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] mem [0:127];

  always #5 clk = ~clk;

  spi_reg_frame_ctrl #(.ADDR_W(7), .IDLE_TX(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .sysClk(clk), .rstN(rstN), .ssN(ssN), .rxByte(rxByte), .rxValid(rxValid),
    .txByte(txByte), .regAddr(regAddr), .regWrEn(regWrEn), .regWrData(regWrData),
    .regRdEn(regRdEn), .regRdData(regRdData), .frameActive(frameActive), .errCount(errCount)
  );

  assign regRdData = mem[regAddr];

  always @(posedge clk) begin
    if (regWrEn) begin
      mem[regAddr] <= regWrData;
      wr_cnt <= wr_cnt + 1;
    end
    if (regRdEn) rd_cnt <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    ssN = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_finish();
    ssN = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rxByte  = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; ssN = 1'b1; rxByte = 8'h00; rxValid = 1'b0;
    repeat (2) tick();
    nvec++; if (txByte !== 8'hA5) begin nerr++; $display("FAIL reset_tx: got %h want a5", txByte); end
    nvec++; if (regAddr !== 7'h00 || regWrData !== 8'h00) begin nerr++; $display("FAIL reset_bus: got addr %h data %h want 00 00", regAddr, regWrData); end
    nvec++; if ({regWrEn, regRdEn, frameActive} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b want 000", {regWrEn, regRdEn, frameActive}); end
    nvec++; if (errCount !== 8'h00) begin nerr++; $display("FAIL reset_err: got %h want 00", errCount); end
    rstN = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    frame_begin();
    nvec++; if (frameActive !== 1'b1) begin nerr++; $display("FAIL wr_active: got %b want 1", frameActive); end
    send(8'h05); tick();
    nvec++; if (regWrEn !== 1'b0) begin nerr++; $display("FAIL wr_cmd_nostrobe: got %b want 0", regWrEn); end
    send(8'h11);
    nvec++; if ({regWrEn, regAddr, regWrData, txByte} !== {1'b1, 7'h05, 8'h11, 8'h11}) begin nerr++;
      $display("FAIL wr_b0: got en %b addr %h data %h tx %h want 1 05 11 11", regWrEn, regAddr, regWrData, txByte); end
    tick();
    nvec++; if (regWrEn !== 1'b0) begin nerr++; $display("FAIL wr_pulse: got %b want 0", regWrEn); end
    send(8'h22);
    nvec++; if ({regWrEn, regAddr, regWrData, txByte} !== {1'b1, 7'h06, 8'h22, 8'h22}) begin nerr++;
      $display("FAIL wr_b1: got en %b addr %h data %h tx %h want 1 06 22 22", regWrEn, regAddr, regWrData, txByte); end
    frame_finish();
    nvec++; if ({frameActive, txByte} !== {1'b0, 8'hA5}) begin nerr++; $display("FAIL wr_end: got act %b tx %h want 0 a5", frameActive, txByte); end
    nvec++; if (mem[5] !== 8'h11 || mem[6] !== 8'h22 || wr_cnt - w0 != 2) begin nerr++;
      $display("FAIL wr_mem: got %h %h cnt %0d want 11 22 2", mem[5], mem[6], wr_cnt - w0); end
  endtask

  task automatic test_read();
    frame_begin(); send(8'h03); send(8'h3C); send(8'hC3); frame_finish();
    frame_begin();
    send(8'h83);
    nvec++; if ({regRdEn, regWrEn, regAddr} !== {1'b1, 1'b0, 7'h03}) begin nerr++;
      $display("FAIL rd_cmd: got rd %b wr %b addr %h want 1 0 03", regRdEn, regWrEn, regAddr); end
    tick();
    nvec++; if ({txByte, regRdEn} !== {8'h3C, 1'b0}) begin nerr++; $display("FAIL rd_b0: got tx %h rd %b want 3c 0", txByte, regRdEn); end
    repeat (3) tick();
    send(8'h00);
    nvec++; if ({regRdEn, regAddr} !== {1'b1, 7'h04}) begin nerr++; $display("FAIL rd_addr1: got rd %b addr %h want 1 04", regRdEn, regAddr); end
    tick();
    nvec++; if (txByte !== 8'hC3) begin nerr++; $display("FAIL rd_b1: got %h want c3", txByte); end
    frame_finish();
    nvec++; if (txByte !== 8'hA5) begin nerr++; $display("FAIL rd_end_tx: got %h want a5", txByte); end
  endtask

  task automatic test_wrap();
    frame_begin();
    send(8'h7F); tick();
    send(8'hAA);
    nvec++; if ({regWrEn, regAddr} !== {1'b1, 7'h7F}) begin nerr++; $display("FAIL wrap_hi: got en %b addr %h want 1 7f", regWrEn, regAddr); end
    tick();
    send(8'hBB);
    nvec++; if ({regWrEn, regAddr} !== {1'b1, 7'h00}) begin nerr++; $display("FAIL wrap_lo: got en %b addr %h want 1 00", regWrEn, regAddr); end
    frame_finish();
    nvec++; if (mem[0] !== 8'hBB || mem[127] !== 8'hAA) begin nerr++; $display("FAIL wrap_mem: got %h %h want bb aa", mem[0], mem[127]); end
  endtask

  task automatic test_early_ss();
    int w0;
    w0 = wr_cnt;
    frame_begin(); send(8'h10); send(8'h55);
    repeat (2) tick();
    frame_finish();
    nvec++; if ({frameActive, txByte} !== {1'b0, 8'hA5} || wr_cnt - w0 != 1) begin nerr++;
      $display("FAIL early_ss: got act %b tx %h strobes %0d want 0 a5 1", frameActive, txByte, wr_cnt - w0); end
    frame_begin(); send(8'h20); tick();
    ssN = 1'b1;
    repeat (2) tick();
    send(8'h66);
    nvec++; if ({regWrEn, regAddr, regWrData} !== {1'b1, 7'h20, 8'h66}) begin nerr++;
      $display("FAIL same_cyc_strobe: got en %b addr %h data %h want 1 20 66", regWrEn, regAddr, regWrData); end
    nvec++; if ({frameActive, txByte} !== {1'b0, 8'hA5}) begin nerr++; $display("FAIL same_cyc_idle: got act %b tx %h want 0 a5", frameActive, txByte); end
    repeat (2) tick();
    w0 = wr_cnt;
    send(8'h01); tick();
    nvec++; if (wr_cnt != w0 || regRdEn !== 1'b0) begin nerr++; $display("FAIL idle_rx: got strobes %0d rd %b want 0 0", wr_cnt - w0, regRdEn); end
    frame_begin(); repeat (3) tick(); frame_finish();
    nvec++; if (wr_cnt != w0 || errCount !== 8'h00) begin nerr++; $display("FAIL empty_frame: got strobes %0d err %h want 0 00", wr_cnt - w0, errCount); end
  endtask

  task automatic test_reset_mid();
    int w0;
    frame_begin(); send(8'h40); tick();
    w0 = wr_cnt;
    rxByte = 8'h77; rxValid = 1'b1;
    #2 rstN = 1'b0;
    #1;
    nvec++; if ({txByte, regAddr, regWrData, regWrEn, regRdEn, frameActive, errCount} !== {8'hA5, 7'h00, 8'h00, 3'b000, 8'h00}) begin nerr++;
      $display("FAIL rst_mid: got tx %h addr %h data %h flags %b err %h", txByte, regAddr, regWrData, {regWrEn, regRdEn, frameActive}, errCount); end
    tick();
    rxValid = 1'b0; ssN = 1'b1;
    tick();
    nvec++; if (wr_cnt != w0 || regWrEn !== 1'b0) begin nerr++; $display("FAIL rst_mid_strobe: got strobes %0d want 0", wr_cnt - w0); end
    rstN = 1'b1;
    repeat (4) tick();
  endtask

`ifdef SPI_TIMEOUT_EN
  task automatic test_timeout();
    int w0;
    int n;
    frame_begin(); send(8'h01);
    repeat (TMO - 2) tick();
    nvec++; if (txByte !== 8'hA5) begin nerr++; $display("FAIL tmo_early: got %h want a5", txByte); end
    n = 0;
    while (txByte !== 8'hEE && n < 40) begin tick(); n++; end
    nvec++; if (txByte !== 8'hEE || errCount !== 8'h01) begin nerr++; $display("FAIL tmo_abort: got tx %h err %h want ee 01", txByte, errCount); end
    w0 = wr_cnt;
    send(8'h99); tick();
    nvec++; if (wr_cnt != w0 || txByte !== 8'hEE) begin nerr++; $display("FAIL tmo_noStrobe: got strobes %0d tx %h want 0 ee", wr_cnt - w0, txByte); end
    frame_finish();
    for (int i = 0; i < 255; i++) begin
      frame_begin(); repeat (TMO + 4) tick(); frame_finish();
    end
    nvec++; if (errCount !== 8'hFF) begin nerr++; $display("FAIL tmo_sat: got %h want ff", errCount); end
  endtask
`else
  task automatic test_timeout();
    int w0;
    frame_begin(); send(8'h02);
    repeat (TMO * 3) tick();
    nvec++; if (txByte !== 8'hA5 || errCount !== 8'h00) begin nerr++; $display("FAIL no_tmo: got tx %h err %h want a5 00", txByte, errCount); end
    w0 = wr_cnt;
    send(8'h5A);
    nvec++; if ({regWrEn, regAddr} !== {1'b1, 7'h02} || wr_cnt != w0) begin nerr++; $display("FAIL no_tmo_wr: got en %b addr %h want 1 02", regWrEn, regAddr); end
    frame_finish();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_early_ss();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
